// File: rtl/neural_stream_source.sv
// Source endpoint for the neural_data_32 host-read stream: packs 16-bit sample
// pairs into 32-bit words, buffers them in a FIFO and serves the core's rden/empty/eof.
module neural_stream_source #(
  parameter int DEPTH_LOG2 = 10,
  parameter int SAMPLE_W   = 16
) (
  input  logic                    bus_clk_w,
  input  logic                    bus_rst_w,
  input  logic                    sample_valid_w,
  input  logic [SAMPLE_W-1:0]     sample_data_w,
  input  logic                    frame_start_w,
  input  logic                    stop_w,
  input  logic                    user_r_neural_data_32_open_w,
  input  logic                    user_r_neural_data_32_rden_w,
  output logic [2*SAMPLE_W-1:0]   user_r_neural_data_32_data_w,
  output logic                    user_r_neural_data_32_empty_w,
  output logic                    user_r_neural_data_32_eof_w,
  output logic                    overflow_w,
  output logic [DEPTH_LOG2:0]     fill_level_w
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [2*SAMPLE_W-1:0] mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [SAMPLE_W-1:0]   held;
  logic                  half_full;
  logic                  overflow;
  logic [2*SAMPLE_W-1:0] rd_data;

  logic                  accept, push_req, push_ok, drop, pop, open;
  logic [2*SAMPLE_W-1:0] push_data;

  assign open = user_r_neural_data_32_open_w;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    push_req   = 1'b0;
    push_data  = '0;
    pop        = user_r_neural_data_32_rden_w && (count != '0);
    case (state)
      IDLE:  if (open) state_next = SYNC;
      SYNC: begin
        if (stop_w) state_next = DONE;
        else if (sample_valid_w && frame_start_w) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        accept = sample_valid_w;
        if (stop_w) state_next = DRAIN;
      end
      DRAIN: begin
        // Flush a lone held sample as a zero-padded word before finishing.
        if (half_full) begin
          push_req  = 1'b1;
          push_data = {{SAMPLE_W{1'b0}}, held};
        end else if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE:    ;
      default: state_next = IDLE;
    endcase
    if (accept && half_full) begin
      push_req  = 1'b1;
      push_data = {sample_data_w, held};
    end
    drop    = push_req && (count == FULL_COUNT) && !pop;
    push_ok = push_req && !drop;
    // A lost word breaks pair alignment, so wait for the next frame start.
    if (drop && state_next == RUN) state_next = SYNC;
    if (!open) state_next = IDLE;
  end

  always_ff @(posedge bus_clk_w or posedge bus_rst_w) begin
    if (bus_rst_w) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge bus_clk_w) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge bus_clk_w or posedge bus_rst_w) begin
    if (bus_rst_w) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      held      <= '0;
      half_full <= 1'b0;
      overflow  <= 1'b0;
      rd_data   <= '0;
    end else if (!open) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      half_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr];
      end
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (!push_ok && pop) count <= count - CNT_ONE;
      if (drop) overflow <= 1'b1;
      if (drop) begin
        half_full <= 1'b0;
      end else if (accept) begin
        if (half_full) begin
          half_full <= 1'b0;
        end else begin
          held      <= sample_data_w;
          half_full <= 1'b1;
        end
      end else if (state == DRAIN && half_full) begin
        half_full <= 1'b0;
      end
    end
  end

  assign user_r_neural_data_32_data_w  = rd_data;
  assign user_r_neural_data_32_empty_w = (count == '0);
  assign user_r_neural_data_32_eof_w   = (state == DONE) && (count == '0);
  assign overflow_w                    = overflow;
  assign fill_level_w                  = count;

endmodule

// File: tb/tb_neural_stream_source.sv
// Directed bench for neural_stream_source with a 4-word FIFO.
module tb_neural_stream_source;

  localparam int DL2 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] sample = '0;
  logic        fs = 1'b0;
  logic        stop = 1'b0;
  logic        open = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] data;
  logic        empty, eof, ovf;
  logic [DL2:0] fill;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  neural_stream_source #(.DEPTH_LOG2(DL2), .SAMPLE_W(16)) dut (
    .bus_clk_w(clk),
    .bus_rst_w(rst),
    .sample_valid_w(valid),
    .sample_data_w(sample),
    .frame_start_w(fs),
    .stop_w(stop),
    .user_r_neural_data_32_open_w(open),
    .user_r_neural_data_32_rden_w(rden),
    .user_r_neural_data_32_data_w(data),
    .user_r_neural_data_32_empty_w(empty),
    .user_r_neural_data_32_eof_w(eof),
    .overflow_w(ovf),
    .fill_level_w(fill)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s, input logic f);
    valid = 1'b1; sample = s; fs = f;
    tick();
    valid = 1'b0; fs = 1'b0;
  endtask

  task automatic rd();
    rden = 1'b1;
    tick();
    rden = 1'b0;
  endtask

  task automatic reopen();
    open = 1'b0;
    tick();
    open = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL reset_eof got=%b exp=0", eof); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_packing();
    reopen();
    send(16'h1111, 1'b1);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL pack_fill0 got=%0d exp=0", fill); end
    send(16'h2222, 1'b0);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL pack_fill1 got=%0d exp=1", fill); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pack_empty got=%b exp=0", empty); end
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b0);
    checks++; if (fill !== 3'd2) begin errors++; $display("FAIL pack_fill2 got=%0d exp=2", fill); end
    rd();
    checks++; if (data !== 32'h22221111) begin errors++; $display("FAIL pack_word0 got=%h exp=22221111", data); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL pack_fill3 got=%0d exp=1", fill); end
    rd();
    checks++; if (data !== 32'h44443333) begin errors++; $display("FAIL pack_word1 got=%h exp=44443333", data); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL pack_fill4 got=%0d exp=0", fill); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pack_empty_end got=%b exp=1", empty); end
    // Read on empty is ignored: data holds.
    rd();
    checks++; if (data !== 32'h44443333) begin errors++; $display("FAIL pack_underflow got=%h exp=44443333", data); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL pack_underflow_fill got=%0d exp=0", fill); end
  endtask

  task automatic test_sync_gating();
    reopen();
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL sync_unaligned got=%0d exp=0", fill); end
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b0);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL sync_fill got=%0d exp=1", fill); end
    rd();
    checks++; if (data !== 32'h00020001) begin errors++; $display("FAIL sync_word got=%h exp=00020001", data); end
  endtask

  task automatic test_overflow();
    reopen();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      send(16'h0100 + 16'(i), i == 0);
      if (i % 2 == 1 && i < 8) exp_q.push_back({16'h0100 + 16'(i), 16'h0100 + 16'(i - 1)});
    end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovf_fill got=%0d exp=4", fill); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    send(16'h0555, 1'b0);
    send(16'h0666, 1'b0);
    rd();
    checks++; if (fill !== 3'd3) begin errors++; $display("FAIL ovf_no_store got=%0d exp=3", fill); end
    exp_w = exp_q.pop_front();
    checks++; if (data !== exp_w) begin errors++; $display("FAIL ovf_read0 got=%h exp=%h", data, exp_w); end
    for (int k = 1; k < 4; k++) begin
      rd();
      exp_w = exp_q.pop_front();
      checks++; if (data !== exp_w) begin errors++; $display("FAIL ovf_read%0d got=%h exp=%h", k, data, exp_w); end
    end
    send(16'h0777, 1'b1);
    send(16'h0888, 1'b0);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL ovf_resync_fill got=%0d exp=1", fill); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    rd();
    checks++; if (data !== 32'h08880777) begin errors++; $display("FAIL ovf_resync_word got=%h exp=08880777", data); end
  endtask

  task automatic test_odd_drain();
    reopen();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL drain_ovf_cleared got=%b exp=0", ovf); end
    send(16'h0A0A, 1'b1);
    send(16'h0B0B, 1'b0);
    send(16'h0C0C, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++; if (fill !== 3'd2) begin errors++; $display("FAIL drain_fill got=%0d exp=2", fill); end
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL drain_eof_early got=%b exp=0", eof); end
    rd();
    checks++; if (data !== 32'h0B0B0A0A) begin errors++; $display("FAIL drain_word0 got=%h exp=0b0b0a0a", data); end
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL drain_eof_mid got=%b exp=0", eof); end
    rd();
    checks++; if (data !== 32'h00000C0C) begin errors++; $display("FAIL drain_word1 got=%h exp=00000c0c", data); end
    tick();
    checks++; if (eof !== 1'b1) begin errors++; $display("FAIL drain_eof got=%b exp=1", eof); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    tick();
    checks++; if (eof !== 1'b1) begin errors++; $display("FAIL drain_eof_hold got=%b exp=1", eof); end
    open = 1'b0;
    tick();
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL drain_eof_close got=%b exp=0", eof); end
  endtask

  task automatic test_full_rw();
    reopen();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(16'h2000 + 16'(i), i == 0);
      if (i % 2 == 1) exp_q.push_back({16'h2000 + 16'(i), 16'h2000 + 16'(i - 1)});
    end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL full_fill got=%0d exp=4", fill); end
    send(16'h3A3A, 1'b1);
    exp_q.push_back(32'h3B3B3A3A);
    valid = 1'b1; sample = 16'h3B3B; rden = 1'b1;
    tick();
    valid = 1'b0; rden = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_rw_ovf got=%b exp=0", ovf); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL full_rw_fill got=%0d exp=4", fill); end
    exp_w = exp_q.pop_front();
    checks++; if (data !== exp_w) begin errors++; $display("FAIL full_rw_read0 got=%h exp=%h", data, exp_w); end
    for (int k = 1; k < 5; k++) begin
      rd();
      exp_w = exp_q.pop_front();
      checks++; if (data !== exp_w) begin errors++; $display("FAIL full_rw_read%0d got=%h exp=%h", k, data, exp_w); end
    end
  endtask

  task automatic test_close_reset();
    reopen();
    for (int i = 0; i < 6; i++) send(16'h4000 + 16'(i), i == 0);
    checks++; if (fill !== 3'd3) begin errors++; $display("FAIL close_pre_fill got=%0d exp=3", fill); end
    open = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL close_empty got=%b exp=1", empty); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL close_fill got=%0d exp=0", fill); end
    checks++; if (ovf !== 1'b0 || eof !== 1'b0) begin errors++; $display("FAIL close_flags got=%b%b exp=00", ovf, eof); end
    open = 1'b1;
    tick();
    send(16'h5001, 1'b0);
    send(16'h5002, 1'b0);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL close_resync got=%0d exp=0", fill); end
    send(16'h5003, 1'b1);
    send(16'h5004, 1'b0);
    send(16'h5005, 1'b0);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL close_run_fill got=%0d exp=1", fill); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fill !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rst_async got=%0d/%b exp=0/1", fill, empty); end
    checks++; if (ovf !== 1'b0 || eof !== 1'b0 || data !== 32'h0) begin errors++; $display("FAIL rst_flags got=%b%b %h exp=00 0", ovf, eof, data); end
    tick();
    rst = 1'b0;
    tick();
    send(16'h6001, 1'b0);
    send(16'h6002, 1'b0);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_resync got=%0d exp=0", fill); end
    send(16'h6003, 1'b1);
    send(16'h6004, 1'b0);
    rd();
    checks++; if (data !== 32'h60046003) begin errors++; $display("FAIL rst_word got=%h exp=60046003", data); end
  endtask

  initial begin
    test_reset();
    test_basic_packing();
    test_sync_gating();
    test_overflow();
    test_odd_drain();
    test_full_rw();
    test_close_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
